// File: rtl/sixty_sec_timer.sv
// ============================================================================
// Module   : sixty_sec_timer
// Brief    : BCD countdown timer with start/pause/clear control, paced by a
//            synchronized ~1 Hz slow_clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sixty_sec_timer #(
  parameter int unsigned START_SECS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       expired
);

  localparam logic [3:0] C_TENS = 4'(START_SECS / 10);
  localparam logic [3:0] C_ONES = 4'(START_SECS % 10);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_expired;
  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       w_tick;
  logic       w_last;

  // Two synchronizer stages plus a history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= slow_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_tick = r_s2 & ~r_s3;
  // 01 (or a defensive 00) is the final step; never borrow below zero.
  assign w_last = (r_tens == 4'd0) && (r_ones <= 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tens    <= C_TENS;
      r_ones    <= C_ONES;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_tens  <= C_TENS;
        r_ones  <= C_ONES;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tens <= C_TENS;
            r_ones <= C_ONES;
            if (start && !pause) r_state <= S_RUN;
          end
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSE;
            end else if (w_tick) begin
              if (w_last) begin
                r_tens    <= 4'd0;
                r_ones    <= 4'd0;
                r_state   <= S_DONE;
                r_expired <= 1'b1;
              end else if (r_ones != 4'd0) begin
                r_ones <= r_ones - 4'd1;
              end else begin
                r_ones <= 4'd9;
                r_tens <= r_tens - 4'd1;
              end
            end
          end
          S_PAUSE: begin
            if (start && !pause) r_state <= S_RUN;
          end
          S_DONE: begin
            if (start) begin
              r_tens  <= C_TENS;
              r_ones  <= C_ONES;
              r_state <= S_RUN;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign expired = r_expired;
  assign running = (r_state == S_RUN);
  assign paused  = (r_state == S_PAUSE);
  assign done    = (r_state == S_DONE);

endmodule

`default_nettype wire
